// File: rtl/sprite_frame_scheduler.sv
// rtl/sprite_frame_scheduler.sv - per-frame erase/redraw pixel sequencer for sprite channels; optional clipping via `define CLIP_EN
module sprite_frame_scheduler #(
   parameter int NUM_SPRITES = 7,
   parameter int X_W         = 8,
   parameter int Y_W         = 7,
   parameter int COLOUR_W    = 3,
   parameter int SPR_W       = 6,
   parameter int SPR_H       = 7,
   // duck: bit j*SPR_W+i set means pixel (i,j) is opaque; one 6-bit row per group, row 0 rightmost
   parameter logic [SPR_W*SPR_H-1:0] SPR_MASK =
      42'b000000_000000_011110_011100_001000_001110_001100,
   parameter logic [COLOUR_W-1:0] BG_COLOUR = '0,
   parameter int SCREEN_W    = 160,
   parameter int SCREEN_H    = 120
) (
   input  logic                            clock,
   input  logic                            resetn,
   input  logic                            frame_tick,
   input  logic [NUM_SPRITES-1:0]          spr_en,
   input  logic [NUM_SPRITES*X_W-1:0]      spr_x,
   input  logic [NUM_SPRITES*Y_W-1:0]      spr_y,
   input  logic [NUM_SPRITES*COLOUR_W-1:0] spr_colour,
   input  logic                            plot_ready,
   output logic [X_W-1:0]                  x_out,
   output logic [Y_W-1:0]                  y_out,
   output logic [COLOUR_W-1:0]             colour,
   output logic                            plot,
   output logic                            busy,
   output logic                            frame_done,
   output logic                            overrun
);

   localparam int KW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
   localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
   localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
   localparam logic [63:0] MASK64 = 64'(SPR_MASK);

   // Reject configurations the raster counters and mask index cannot cover
   if (NUM_SPRITES < 1 || NUM_SPRITES > 16 || SPR_W < 1 || SPR_W > 8 ||
       SPR_H < 1 || SPR_H > 8 || SCREEN_W < 1 || SCREEN_H < 1) begin : g_param_check
      $error("sprite_frame_scheduler: parameter out of range");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_ERASE,
      S_DRAW,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t                        state, state_nx;
   logic [KW-1:0]                 k, k_nx;
   logic [CW-1:0]                 col, col_nx;
   logic [RW-1:0]                 row, row_nx;
   logic [NUM_SPRITES-1:0]        drawn, drawn_nx;
   logic                          capture, load_pix, latch_old;

   logic [NUM_SPRITES-1:0]        sh_en;
   logic [NUM_SPRITES*X_W-1:0]    sh_x;
   logic [NUM_SPRITES*Y_W-1:0]    sh_y;
   logic [NUM_SPRITES*COLOUR_W-1:0] sh_colour;
   logic [X_W-1:0]                old_x [NUM_SPRITES];
   logic [Y_W-1:0]                old_y [NUM_SPRITES];

   logic                          adv;
   logic                          step_last, k_last, row_end;
   logic [X_W-1:0]                anc_x;
   logic [Y_W-1:0]                anc_y;
   logic [COLOUR_W-1:0]           pix_colour;
   logic [X_W-1:0]                pix_x;
   logic [Y_W-1:0]                pix_y;
   logic [5:0]                    mask_idx;
   logic                          mask_bit, pix_vis;

   // Output stage is free when it holds no pixel or the sink takes the one it holds
   assign adv       = !plot || plot_ready;
   assign row_end   = (col == CW'(SPR_W - 1));
   assign step_last = row_end && (row == RW'(SPR_H - 1));
   assign k_last    = (k == KW'(NUM_SPRITES - 1));
   assign mask_idx  = 6'(row) * 6'(SPR_W) + 6'(col);
   assign mask_bit  = MASK64[mask_idx];

   // Anchor and colour of the raster pass in progress: last drawn spot for erase, snapshot for draw
   always_comb begin
      anc_x      = old_x[k];
      anc_y      = old_y[k];
      pix_colour = BG_COLOUR;
      if (state == S_DRAW) begin
         anc_x      = sh_x[k*X_W +: X_W];
         anc_y      = sh_y[k*Y_W +: Y_W];
         pix_colour = sh_colour[k*COLOUR_W +: COLOUR_W];
      end
   end

`ifdef CLIP_EN
   logic [X_W:0] px_full;
   logic [Y_W:0] py_full;
   assign px_full = {1'b0, anc_x} + (X_W+1)'(col);
   assign py_full = {1'b0, anc_y} + (Y_W+1)'(row);
   assign pix_x   = px_full[X_W-1:0];
   assign pix_y   = py_full[Y_W-1:0];
   // Off-screen or carried-out positions still take their step but never plot
   assign pix_vis = !px_full[X_W] && !py_full[Y_W] &&
                    (32'(pix_x) < 32'(SCREEN_W)) && (32'(pix_y) < 32'(SCREEN_H));
`else
   assign pix_x   = anc_x + X_W'(col);
   assign pix_y   = anc_y + Y_W'(row);
   assign pix_vis = 1'b1;
`endif

   // Next-state logic: channel scan, erase/draw raster walk, frame completion
   always_comb begin
      state_nx  = state;
      k_nx      = k;
      col_nx    = col;
      row_nx    = row;
      drawn_nx  = drawn;
      capture   = 1'b0;
      load_pix  = 1'b0;
      latch_old = 1'b0;
      case (state)
         S_IDLE: begin
            if (frame_tick) begin
               capture  = 1'b1;
               k_nx     = '0;
               state_nx = S_SCAN;
            end
         end
         S_SCAN: begin
            if (adv) begin
               col_nx = '0;
               row_nx = '0;
               if (drawn[k])
                  state_nx = S_ERASE;
               else if (sh_en[k])
                  state_nx = S_DRAW;
               else if (k_last)
                  state_nx = S_DONE;
               else
                  k_nx = k + KW'(1);
            end
         end
         S_ERASE: begin
            if (adv) begin
               load_pix = 1'b1;
               if (step_last) begin
                  col_nx = '0;
                  row_nx = '0;
                  if (sh_en[k]) begin
                     state_nx = S_DRAW;
                  end else begin
                     drawn_nx[k] = 1'b0;
                     if (k_last) begin
                        state_nx = S_FLUSH;
                     end else begin
                        k_nx     = k + KW'(1);
                        state_nx = S_SCAN;
                     end
                  end
               end else if (row_end) begin
                  col_nx = '0;
                  row_nx = row + RW'(1);
               end else begin
                  col_nx = col + CW'(1);
               end
            end
         end
         S_DRAW: begin
            if (adv) begin
               load_pix = 1'b1;
               if (step_last) begin
                  col_nx      = '0;
                  row_nx      = '0;
                  drawn_nx[k] = 1'b1;
                  latch_old   = 1'b1;
                  if (k_last) begin
                     state_nx = S_FLUSH;
                  end else begin
                     k_nx     = k + KW'(1);
                     state_nx = S_SCAN;
                  end
               end else if (row_end) begin
                  col_nx = '0;
                  row_nx = row + RW'(1);
               end else begin
                  col_nx = col + CW'(1);
               end
            end
         end
         // Hold frame_done back until the final pixel has left the output register
         S_FLUSH: begin
            if (adv)
               state_nx = S_DONE;
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Sequencer state register
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= S_IDLE;
         k     <= '0;
         col   <= '0;
         row   <= '0;
         drawn <= '0;
      end else begin
         state <= state_nx;
         k     <= k_nx;
         col   <= col_nx;
         row   <= row_nx;
         drawn <= drawn_nx;
      end
   end

   // Snapshot of the sprite sources taken on the accepted frame tick
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sh_en     <= '0;
         sh_x      <= '0;
         sh_y      <= '0;
         sh_colour <= '0;
      end else if (capture) begin
         sh_en     <= spr_en;
         sh_x      <= spr_x;
         sh_y      <= spr_y;
         sh_colour <= spr_colour;
      end
   end

   // Remember where each channel was last drawn so the next frame can erase it
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int n = 0; n < NUM_SPRITES; n++) begin
            old_x[n] <= '0;
            old_y[n] <= '0;
         end
      end else if (latch_old) begin
         old_x[k] <= anc_x;
         old_y[k] <= anc_y;
      end
   end

   // Registered pixel port; frozen while a plotted pixel waits for plot_ready
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         x_out  <= '0;
         y_out  <= '0;
         colour <= '0;
         plot   <= 1'b0;
      end else if (load_pix) begin
         x_out  <= pix_x;
         y_out  <= pix_y;
         colour <= pix_colour;
         plot   <= mask_bit && pix_vis;
      end else if (adv) begin
         plot   <= 1'b0;
      end
   end

   // Sticky flag for ticks that arrive while an update is still running
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         overrun <= 1'b0;
      else if (frame_tick && (state != S_IDLE))
         overrun <= 1'b1;
   end

   assign busy       = (state != S_IDLE);
   assign frame_done = (state == S_DONE);

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// tb/tb_sprite_frame_scheduler.sv - self-checking bench for sprite_frame_scheduler
module tb_sprite_frame_scheduler;

   localparam int NS = 3;

   logic          clock = 1'b0;
   logic          resetn;
   logic          frame_tick;
   logic [NS-1:0] spr_en;
   logic [NS*8-1:0] spr_x;
   logic [NS*7-1:0] spr_y;
   logic [NS*3-1:0] spr_colour;
   logic          plot_ready;
   logic [7:0]    x_out;
   logic [6:0]    y_out;
   logic [2:0]    colour;
   logic          plot, busy, frame_done, overrun;

   logic          tick2;
   logic [0:0]    en2;
   logic [7:0]    x2;
   logic [6:0]    y2;
   logic [2:0]    c2;
   logic          ready2;
   logic [7:0]    x_out2;
   logic [6:0]    y_out2;
   logic [2:0]    colour2;
   logic          plot2, busy2, frame_done2, overrun2;

   always #5 clock = ~clock;

   sprite_frame_scheduler #(.NUM_SPRITES(NS)) u_dut (
      .clock(clock), .resetn(resetn), .frame_tick(frame_tick), .spr_en(spr_en),
      .spr_x(spr_x), .spr_y(spr_y), .spr_colour(spr_colour), .plot_ready(plot_ready),
      .x_out(x_out), .y_out(y_out), .colour(colour), .plot(plot), .busy(busy),
      .frame_done(frame_done), .overrun(overrun)
   );

   sprite_frame_scheduler #(.NUM_SPRITES(1), .SPR_MASK('1)) u_full (
      .clock(clock), .resetn(resetn), .frame_tick(tick2), .spr_en(en2),
      .spr_x(x2), .spr_y(y2), .spr_colour(c2), .plot_ready(ready2),
      .x_out(x_out2), .y_out(y_out2), .colour(colour2), .plot(plot2), .busy(busy2),
      .frame_done(frame_done2), .overrun(overrun2)
   );

   int n_checks = 0;
   int n_errors = 0;
   int ready_mode = 0;
   int done_cnt = 0;
   int done2_cnt = 0;

   logic [17:0] exp_q[$];
   logic [17:0] got_q[$];
   logic [17:0] got2_q[$];

   bit m_drawn[NS];
   int m_ox[NS];
   int m_oy[NS];
   bit m2_drawn;
   int m2_ox, m2_oy;

   string duck[7] = '{"..##..", ".###..", "...#..", "..###.", ".####.", "......", "......"};

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit duck_opaque(int i, int j);
      string s;
      s = duck[j];
      return s[i] == "#";
   endfunction

   task automatic push_sprite(int ax, int ay, int c, bit full);
      for (int j = 0; j < 7; j++)
         for (int i = 0; i < 6; i++)
            if (full || duck_opaque(i, j))
               exp_q.push_back({8'((ax + i) % 256), 7'((ay + j) % 128), 3'(c)});
   endtask

   task automatic model_main();
      int ax, ay, c;
      exp_q.delete();
      for (int k = 0; k < NS; k++) begin
         ax = int'(spr_x[k*8 +: 8]);
         ay = int'(spr_y[k*7 +: 7]);
         c  = int'(spr_colour[k*3 +: 3]);
         if (m_drawn[k]) push_sprite(m_ox[k], m_oy[k], 0, 1'b0);
         if (spr_en[k]) begin
            push_sprite(ax, ay, c, 1'b0);
            m_drawn[k] = 1'b1;
            m_ox[k] = ax;
            m_oy[k] = ay;
         end else begin
            m_drawn[k] = 1'b0;
         end
      end
   endtask

   task automatic model_full();
      exp_q.delete();
      if (m2_drawn) push_sprite(m2_ox, m2_oy, 0, 1'b1);
      if (en2[0]) begin
         push_sprite(int'(x2), int'(y2), int'(c2), 1'b1);
         m2_drawn = 1'b1;
         m2_ox = int'(x2);
         m2_oy = int'(y2);
      end else begin
         m2_drawn = 1'b0;
      end
   endtask

   task automatic compare_pixels(string tag, bit second);
      logic [17:0] g[$];
      int e0;
      if (second) g = got2_q; else g = got_q;
      check({tag, "_count"}, g.size(), exp_q.size());
      e0 = n_errors;
      for (int i = 0; i < g.size() && i < exp_q.size(); i++) begin
         check({tag, "_pixel"}, g[i], exp_q[i]);
         if (n_errors - e0 > 3) break;
      end
   endtask

   task automatic wait_done(string tag, bit second, int start);
      int n = 0;
      while (((second ? done2_cnt : done_cnt) == start) && n < 4000) begin
         @(posedge clock);
         n++;
      end
      check({tag, "_done_seen"}, n < 4000, 1);
      repeat (2) @(posedge clock);
   endtask

   task automatic set_ch0(bit en, int x, int y, int c);
      spr_en = '0;
      spr_en[0] = en;
      spr_x = 24'($urandom);
      spr_y = 21'($urandom);
      spr_colour = 9'($urandom);
      spr_x[7:0] = 8'(x);
      spr_y[6:0] = 7'(y);
      spr_colour[2:0] = 3'(c);
   endtask

   task automatic run_frame(string tag);
      int start;
      model_main();
      got_q.delete();
      start = done_cnt;
      @(posedge clock); #1 frame_tick = 1'b1;
      @(posedge clock); #1 frame_tick = 1'b0;
      spr_en = 3'($urandom);
      spr_x = 24'($urandom);
      spr_y = 21'($urandom);
      spr_colour = 9'($urandom);
      wait_done(tag, 1'b0, start);
      compare_pixels(tag, 1'b0);
   endtask

   task automatic run_full(string tag);
      int start;
      model_full();
      got2_q.delete();
      start = done2_cnt;
      @(posedge clock); #1 tick2 = 1'b1;
      @(posedge clock); #1 tick2 = 1'b0;
      wait_done(tag, 1'b1, start);
      compare_pixels(tag, 1'b1);
   endtask

   initial begin
      forever begin
         @(posedge clock);
         #1;
         case (ready_mode)
            0: plot_ready = 1'b1;
            1: plot_ready = ~plot_ready;
            default: plot_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin
      bit stall_prev = 1'b0;
      logic [18:0] stall_val = '0;
      forever begin
         @(negedge clock);
         if (!resetn) begin
            stall_prev = 1'b0;
         end else begin
            if (plot && plot_ready) got_q.push_back({x_out, y_out, colour});
            if (plot2 && ready2) got2_q.push_back({x_out2, y_out2, colour2});
            if (frame_done) done_cnt++;
            if (frame_done2) done2_cnt++;
            if (stall_prev) begin
               n_checks++;
               assert ({x_out, y_out, colour, plot} === stall_val) else begin
                  n_errors++;
                  $error("FAIL hold_stable observed=%0h expected=%0h", {x_out, y_out, colour, plot}, stall_val);
               end
            end
            stall_prev = plot && !plot_ready;
            stall_val  = {x_out, y_out, colour, plot};
         end
      end
   end

   initial begin
      int cyc;
      int start;
      resetn = 1'b0;
      frame_tick = 1'b0;
      tick2 = 1'b0;
      plot_ready = 1'b1;
      ready2 = 1'b1;
      spr_en = '0; spr_x = '0; spr_y = '0; spr_colour = '0;
      en2 = '0; x2 = '0; y2 = '0; c2 = '0;
      for (int k = 0; k < NS; k++) begin m_drawn[k] = 0; m_ox[k] = 0; m_oy[k] = 0; end
      m2_drawn = 0; m2_ox = 0; m2_oy = 0;
      repeat (3) @(posedge clock);
      #1;
      check("reset_outputs", {x_out, y_out, colour, plot, busy, frame_done, overrun}, 0);
      resetn = 1'b1;
      @(posedge clock); #1;
      check("idle_outputs", {plot, busy, frame_done, overrun}, 0);

      // single channel, then moved, then disabled
      set_ch0(1, 10, 20, 7);
      run_frame("first_frame");
      check("first_frame_plots", got_q.size(), 13);
      set_ch0(1, 11, 20, 7);
      run_frame("second_frame");
      set_ch0(1, 11, 20, 7);
      run_frame("same_position");
      set_ch0(0, 11, 20, 7);
      run_frame("disable_erase");

      // nothing enabled, nothing drawn: frame_done after NS+1 cycles, no plot
      set_ch0(0, 0, 0, 0);
      model_main();
      got_q.delete();
      start = done_cnt;
      @(posedge clock); #1 frame_tick = 1'b1;
      cyc = 0;
      do begin
         @(posedge clock);
         cyc++;
         #1 frame_tick = 1'b0;
         @(negedge clock);
      end while (!frame_done && cyc < 100);
      check("empty_done_latency", cyc, NS + 1);
      check("empty_busy_at_done", busy, 1);
      @(negedge clock);
      check("empty_busy_after", busy, 0);
      repeat (2) @(posedge clock);
      check("empty_plots", got_q.size(), 0);
      check("empty_one_done", done_cnt - start, 1);

      // backpressure: toggling and random ready
      ready_mode = 1;
      set_ch0(1, 40, 50, 3);
      run_frame("bp_toggle_draw");
      set_ch0(1, 44, 52, 6);
      run_frame("bp_toggle_move");
      ready_mode = 2;
      set_ch0(1, 250, 125, 5);
      run_frame("bp_random_wrap");

      // randomised multi-channel frames
      for (int f = 0; f < 12; f++) begin
         ready_mode = $urandom_range(0, 2);
         spr_en = 3'($urandom);
         spr_x = 24'($urandom);
         spr_y = 21'($urandom);
         spr_colour = 9'($urandom);
         run_frame($sformatf("rand%0d", f));
      end

      // overrun: second tick 5 cycles after the first
      ready_mode = 0;
      check("overrun_before", overrun, 0);
      set_ch0(1, 30, 40, 2);
      model_main();
      got_q.delete();
      start = done_cnt;
      @(posedge clock); #1 frame_tick = 1'b1;
      @(posedge clock); #1 frame_tick = 1'b0;
      repeat (4) @(posedge clock);
      #1 frame_tick = 1'b1;
      @(posedge clock); #1 frame_tick = 1'b0;
      wait_done("overrun_frame", 1'b0, start);
      repeat (30) @(posedge clock);
      check("overrun_one_done", done_cnt - start, 1);
      check("overrun_set", overrun, 1);
      compare_pixels("overrun_frame", 1'b0);
      set_ch0(1, 31, 40, 2);
      run_frame("after_overrun");
      check("overrun_sticky", overrun, 1);

      // reset in the middle of a frame
      spr_en = 3'b111;
      spr_x = 24'($urandom);
      spr_y = 21'($urandom);
      spr_colour = 9'($urandom);
      @(posedge clock); #1 frame_tick = 1'b1;
      @(posedge clock); #1 frame_tick = 1'b0;
      repeat (10) @(posedge clock);
      #1 resetn = 1'b0;
      #1;
      check("midreset_outputs", {plot, busy, frame_done, overrun}, 0);
      repeat (2) @(posedge clock);
      #1 resetn = 1'b1;
      for (int k = 0; k < NS; k++) m_drawn[k] = 0;
      m2_drawn = 0;
      spr_en = 3'b111;
      spr_x = 24'($urandom);
      spr_y = 21'($urandom);
      spr_colour = 9'($urandom);
      run_frame("after_reset_draw_only");
      check("after_reset_plots", got_q.size(), 39);

      // full 6x7 mask at the screen corner, then a wrapping move
      en2 = 1'b1; x2 = 8'd157; y2 = 7'd118; c2 = 3'd5;
      run_full("full_corner");
      check("full_corner_plots", got2_q.size(), 42);
      en2 = 1'b1; x2 = 8'd254; y2 = 7'd126; c2 = 3'd6;
      run_full("full_wrap");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
